// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mp_state_t;

  localparam int CHUNK_DEF   = 8;
  localparam int NCHUNKS_DEF = 4;

  function automatic int mp_width(input int chunk, input int nchunks);
    return chunk * nchunks;
  endfunction

endpackage

// File: rtl/mp_add_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its MSB for overflow detection.
module mp_add_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = total[CHUNK-1:0];
  assign cout  = total[CHUNK];
  // The MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
  assign c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add sequencer: one CHUNK-bit adder reused over NCHUNKS cycles, LS chunk first.
// Optional macro MP_ADD_SUB_EN adds a 'sub' port for a-b.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int  CHUNK   = CHUNK_DEF,
  parameter int  NCHUNKS = NCHUNKS_DEF,
  localparam int WIDTH   = mp_width(CHUNK, NCHUNKS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef MP_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int             IDX_W = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNKS - 1);

  mp_state_t        state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] b_cap;
  logic             c_cap;
  logic             accept;
  logic [CHUNK-1:0] a_sl, b_sl, ch_s;
  logic             ch_cout, ch_msb;

`ifdef MP_ADD_SUB_EN
  // Subtraction as a + ~b + 1; cin is ignored in that mode.
  assign b_cap = sub ? ~b : b;
  assign c_cap = sub ? 1'b1 : cin;
`else
  assign b_cap = b;
  assign c_cap = cin;
`endif

  assign accept = start && (state_q != RUN);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  mp_add_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a     (a_sl),
    .b     (b_sl),
    .cin   (carry),
    .s     (ch_s),
    .cout  (ch_cout),
    .c_msb (ch_msb)
  );

  // Operand capture: data only, left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b_cap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= c_cap;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NCHUNKS; i++) begin
        if (idx == IDX_W'(i)) sum[i*CHUNK +: CHUNK] <= ch_s;
      end
      carry <= ch_cout;
      if (idx == LAST) begin
        cout <= ch_cout;
        ovf  <= ch_msb ^ ch_cout;
        idx  <= '0;
      end else begin
        idx  <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq (CHUNK=8, NCHUNKS=4).
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        cin;
`ifdef MP_ADD_SUB_EN
  logic        sub;
`endif
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  int n_asserts = 0;
  int n_fails   = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.CHUNK(8), .NCHUNKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef MP_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; cin = ~ci;
    chk({tag, ".busy0"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      chk({tag, ".nodone"}, {31'd0, done}, 32'd0);
    end
    tick();
    chk({tag, ".done"}, {31'd0, done}, 32'd1);
    chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    tick();
    chk({tag, ".pulse"}, {31'd0, done}, 32'd0);
    chk({tag, ".hold"}, sum, es);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef MP_ADD_SUB_EN
    sub = 1'b0;
`endif
    tick(); tick();
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.sum",  sum, 32'h0);
    chk("rst.cout", {31'd0, cout}, 32'd0);
    chk("rst.ovf",  {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("mixed", 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 32'h2143_6588, 1'b0, 1'b0);

    // start while busy must be ignored
    a = 32'h10; b = 32'h20; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.busy", {31'd0, busy}, 32'd1);
    tick();
    a = 32'hFF; b = 32'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.busy2", {31'd0, busy}, 32'd1);
    chk("ign.nodone2", {31'd0, done}, 32'd0);
    tick();
    chk("ign.nodone3", {31'd0, done}, 32'd0);
    tick();
    chk("ign.done", {31'd0, done}, 32'd1);
    chk("ign.sum", sum, 32'h0000_0030);
    tick();
    chk("ign.single", {31'd0, done}, 32'd0);
    chk("ign.idle", {31'd0, busy}, 32'd0);

    // reset mid-operation abandons it
    a = 32'h0102_0304; b = 32'h1111_1111; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rmid.busy", {31'd0, busy}, 32'd0);
    chk("rmid.sum", sum, 32'h0);
    chk("rmid.done", {31'd0, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rmid.nodone", {31'd0, done}, 32'd0);
    end
    run_op("after", 32'd5, 32'd7, 1'b0, 32'h0000_000C, 1'b0, 1'b0);

    // back-to-back with start held high
    a = 32'd1; b = 32'd2; cin = 1'b0; start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk("b2b.done1", {31'd0, done}, 32'd1);
    chk("b2b.sum1", sum, 32'h3);
    a = 32'd3; b = 32'd4;
    tick();
    chk("b2b.busy", {31'd0, busy}, 32'd1);
    chk("b2b.nodone", {31'd0, done}, 32'd0);
    chk("b2b.clr", sum, 32'h0);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk("b2b.done2", {31'd0, done}, 32'd1);
    chk("b2b.sum2", sum, 32'h7);
    start = 1'b0;
    tick();
    chk("b2b.idle", {31'd0, busy}, 32'd0);

`ifdef MP_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub", 32'd5, 32'd7, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
